// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg
// Shared definitions for the bitcoin hash engine and its downstream stages.
// Contents:
//   NUM_NONCES_DEFAULT : default number of nonces hashed per job
//   sel_state_t        : state encoding of the nonce result selector
//   idx_width()        : width of a counter able to index n nonces (at least 1)
package bitcoin_pkg;

    localparam int NUM_NONCES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WR0,
        ST_WR1
    } sel_state_t;

    // $clog2(1) is 0, which would make a zero-width index, so clamp to 1.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nonce_result_selector_min_tracker.sv
// nonce_result_selector_min_tracker
// Registered running minimum of a stream of 32-bit words plus the index of
// the word that produced it.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart tracking (min = all ones, index = 0)
//   valid        : word/idx carry a candidate this cycle
//   word, idx    : candidate value and its nonce index
//   min_val      : smallest word seen since the last clear
//   min_idx      : index of min_val
module nonce_result_selector_min_tracker #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      word,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      min_val,
    output logic [IDX_W-1:0] min_idx
);

    logic [31:0]      min_next;
    logic [IDX_W-1:0] idx_next;

    // Strict less-than keeps the earliest index when several words tie.
    always_comb begin
        min_next = min_val;
        idx_next = min_idx;
        if (clear) begin
            min_next = 32'hFFFF_FFFF;
            idx_next = '0;
        end else if (valid && (word < min_val)) begin
            min_next = word;
            idx_next = idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_val <= 32'hFFFF_FFFF;
            min_idx <= '0;
        end else begin
            min_val <= min_next;
            min_idx <= idx_next;
        end
    end

endmodule

// File: rtl/nonce_result_selector.sv
// nonce_result_selector
// Reads NUM_NONCES hash words back from memory starting at hash_addr, finds
// the smallest one, compares it against a difficulty target and writes a
// two-word result record at result_addr:
//   word 0 : {found, 31-bit index of the minimum}
//   word 1 : the minimum hash word
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : begin a scan (only honoured while idle)
//   hash_addr         : address of hash word 0 (captured at start)
//   result_addr       : address of result word 0 (captured at start)
//   target            : unsigned difficulty target (captured at start)
//   done              : idle and not starting a new scan
//   found             : last scan's minimum < target
//   best_nonce        : index of last scan's minimum, zero-extended
//   best_hash         : value of last scan's minimum
//   mem_clk           : memory clock, same as clk
//   mem_we, mem_addr, mem_write_data, mem_read_data : single-port
//                       synchronous memory with one cycle of read latency
module nonce_result_selector
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
    parameter int IDX_W      = idx_width(NUM_NONCES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // One extra bit so the counter can hold NUM_NONCES itself.
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] INC_LIMIT = CNT_W'(NUM_NONCES - 1);

    sel_state_t       state;
    sel_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      result_addr_q;
    logic [31:0]      target_q;

    logic             cmp_valid;
    logic [IDX_W-1:0] cmp_idx;
    logic             min_clear;
    logic             found_next;
    logic [31:0]      min_val;
    logic [IDX_W-1:0] min_idx;

    assign mem_clk = clk;

    // cnt counts READ edges since the start edge. The read data lags the
    // address by two edges, so the word seen when cnt==k is word k-1, and
    // the last word arrives when cnt==NUM_NONCES.
    always_comb begin
        cmp_valid  = (state == ST_READ) && (cnt != '0);
        cmp_idx    = IDX_W'(cnt - CNT_W'(1));
        min_clear  = (state == ST_IDLE) && start;
        found_next = (min_val < target_q);
    end

    nonce_result_selector_min_tracker #(
        .IDX_W (IDX_W)
    ) u_min_tracker (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (min_clear),
        .valid   (cmp_valid),
        .word    (mem_read_data),
        .idx     (cmp_idx),
        .min_val (min_val),
        .min_idx (min_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_READ;
            ST_READ: if (cnt == LAST_CNT) state_next = ST_WR0;
            ST_WR0:  state_next = ST_WR1;
            ST_WR1:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath. The IDLE edge always clears mem_we,
    // which ends the second result write; if start is still high the next
    // scan is launched on that same edge and done stays low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b1;
            found          <= 1'b0;
            best_nonce     <= '0;
            best_hash      <= 32'hFFFF_FFFF;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            cnt            <= '0;
            result_addr_q  <= '0;
            target_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        done          <= 1'b0;
                        mem_addr      <= hash_addr;
                        result_addr_q <= result_addr;
                        target_q      <= target;
                        cnt           <= '0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                ST_READ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt < INC_LIMIT) begin
                        mem_addr <= mem_addr + 16'd1;
                    end
                end
                ST_WR0: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= result_addr_q;
                    mem_write_data <= {found_next, 31'(min_idx)};
                end
                ST_WR1: begin
                    mem_addr       <= result_addr_q + 16'd1;
                    mem_write_data <= min_val;
                    found          <= found_next;
                    best_nonce     <= 8'(min_idx);
                    best_hash      <= min_val;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_selector.sv
// tb_nonce_result_selector
// Drives scans through nonce_result_selector against a one-cycle-latency
// memory model. Expected result-record writes are queued when a scan is set
// up and checked by a write monitor as the DUT issues them.
module tb_nonce_result_selector;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];
    logic [31:0] words [16];
    logic [47:0] sb [$];
    int          checks;
    int          failures;

    nonce_result_selector #(
        .NUM_NONCES (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: address in cycle c, data sampled at the end of c+1.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_write_data;
    end

    // Scoreboard side: every write the DUT is about to commit must match the queue head.
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write got addr=%h data=%h want no write", mem_addr, mem_write_data);
            end else begin
                logic [47:0] exp_w;
                exp_w = sb.pop_front();
                if ({mem_addr, mem_write_data} !== exp_w)
                begin
                    failures++;
                    $display("[TB] FAIL result_write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_write_data, exp_w[47:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic load_words(input logic [15:0] base);
        for (int i = 0; i < 16; i++) mem[16'(base + 16'(i))] = words[i];
    endtask

    task automatic push_expect(input logic [15:0] ra, input logic [7:0] idx,
                               input logic [31:0] h, input logic f);
        sb.push_back({ra, f, 23'd0, idx});
        sb.push_back({16'(ra + 16'd1), h});
    endtask

    function automatic void ref_min(output logic [31:0] mv, output logic [7:0] mi);
        mv = 32'hFFFF_FFFF;
        mi = 8'd0;
        for (int i = 0; i < 16; i++) begin
            if (words[i] < mv) begin
                mv = words[i];
                mi = 8'(i);
            end
        end
    endfunction

    // Pulses start for one edge and returns the number of edges until done rises (-1 on timeout).
    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                            input logic [31:0] tg, output int edges);
        @(negedge clk);
        hash_addr   = ha;
        result_addr = ra;
        target      = tg;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we got=%b want=0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        checks++; if (mem_write_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata got=%h want=0", mem_write_data); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL reset_done got=%b want=1", done); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL reset_found got=%b want=0", found); end
        checks++; if (best_nonce !== 8'h0) begin failures++; $display("[TB] FAIL reset_best_nonce got=%h want=00", best_nonce); end
        checks++; if (best_hash !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL reset_best_hash got=%h want=ffffffff", best_hash); end
        checks++; if (mem_clk !== clk) begin failures++; $display("[TB] FAIL mem_clk got=%b want=%b", mem_clk, clk); end
    endtask

    task automatic test_single_min();
        int edges;
        for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
        words[9] = 32'h0000_0ABC;
        load_words(16'h1000);
        push_expect(16'h2000, 8'd9, 32'h0000_0ABC, 1'b1);
        run_scan(16'h1000, 16'h2000, 32'h0001_0000, edges);
        checks++; if (edges !== 20) begin failures++; $display("[TB] FAIL single_done_latency got=%0d want=20", edges); end
        checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL single_found got=%b want=1", found); end
        checks++; if (best_nonce !== 8'd9) begin failures++; $display("[TB] FAIL single_nonce got=%0d want=9", best_nonce); end
        checks++; if (best_hash !== 32'h0000_0ABC) begin failures++; $display("[TB] FAIL single_hash got=%h want=00000abc", best_hash); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL single_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_tie();
        int edges;
        for (int i = 0; i < 16; i++) words[i] = 32'h0010_0000;
        words[3] = 32'h0000_0010;
        words[7] = 32'h0000_0010;
        load_words(16'h1000);
        push_expect(16'h2000, 8'd3, 32'h0000_0010, 1'b0);
        run_scan(16'h1000, 16'h2000, 32'h0000_0001, edges);
        checks++; if (best_nonce !== 8'd3) begin failures++; $display("[TB] FAIL tie_nonce got=%0d want=3", best_nonce); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL tie_found got=%b want=0", found); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL tie_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_equal_target();
        int edges;
        for (int i = 0; i < 16; i++) words[i] = 32'h2000_0000 + 32'(i);
        words[5] = 32'h1000_0000;
        load_words(16'h1000);
        push_expect(16'h2000, 8'd5, 32'h1000_0000, 1'b0);
        run_scan(16'h1000, 16'h2000, 32'h1000_0000, edges);
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL equal_found got=%b want=0", found); end
        checks++; if (best_hash !== 32'h1000_0000) begin failures++; $display("[TB] FAIL equal_hash got=%h want=10000000", best_hash); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL equal_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_all_ones();
        int edges;
        for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
        load_words(16'h1000);
        push_expect(16'h2000, 8'd0, 32'hFFFF_FFFF, 1'b0);
        run_scan(16'h1000, 16'h2000, 32'hFFFF_FFFF, edges);
        checks++; if (best_nonce !== 8'd0) begin failures++; $display("[TB] FAIL ones_nonce got=%0d want=0", best_nonce); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL ones_found got=%b want=0", found); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL ones_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_addr_wrap();
        int edges;
        for (int i = 0; i < 16; i++) words[i] = 32'h0000_1000 + 32'(i);
        words[15] = 32'h0000_0000;
        load_words(16'hFFF8);
        push_expect(16'h0100, 8'd15, 32'h0000_0000, 1'b1);
        run_scan(16'hFFF8, 16'h0100, 32'h0000_0001, edges);
        checks++; if (best_nonce !== 8'd15) begin failures++; $display("[TB] FAIL wrap_nonce got=%0d want=15", best_nonce); end
        checks++; if (best_hash !== 32'h0) begin failures++; $display("[TB] FAIL wrap_hash got=%h want=00000000", best_hash); end
        checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL wrap_found got=%b want=1", found); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL wrap_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_reset_mid_scan();
        int          edges;
        logic [31:0] mv;
        logic [7:0]  mi;
        bit          saw_we;
        for (int i = 0; i < 16; i++) words[i] = 32'h0000_0100 + 32'(i);
        words[2] = 32'h0000_0004;
        load_words(16'h3000);
        // Abort during READ cycle 8: no writes are queued, so any write is flagged.
        @(negedge clk);
        hash_addr = 16'h3000; result_addr = 16'h3100; target = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_read_mem_we got=%b want=0", mem_we); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_read_done got=%b want=1", done); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL rst_read_found got=%b want=0", found); end
        checks++; if (best_nonce !== 8'h0) begin failures++; $display("[TB] FAIL rst_read_nonce got=%h want=00", best_nonce); end
        checks++; if (best_hash !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rst_read_hash got=%h want=ffffffff", best_hash); end
        @(negedge clk);
        reset_n = 1'b1;
        // Abort while the result record is being written.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_we = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (mem_we) begin
                saw_we = 1'b1;
                break;
            end
        end
        checks++; if (saw_we !== 1'b1) begin failures++; $display("[TB] FAIL rst_write_reach got=%b want=1", saw_we); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_write_mem_we got=%b want=0", mem_we); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_write_done got=%b want=1", done); end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_idle_done got=%b want=1", done); end
        // Fresh scan after release must be clean.
        ref_min(mv, mi);
        push_expect(16'h3100, mi, mv, mv < 32'h0000_0010);
        run_scan(16'h3000, 16'h3100, 32'h0000_0010, edges);
        checks++; if (edges !== 20) begin failures++; $display("[TB] FAIL rst_rescan_latency got=%0d want=20", edges); end
        checks++; if (best_nonce !== 8'd2) begin failures++; $display("[TB] FAIL rst_rescan_nonce got=%0d want=2", best_nonce); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL rst_rescan_writes_left got=%0d want=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bit          done_rose;
        bit          started2;
        int          edges;
        logic [31:0] mv;
        logic [7:0]  mi;
        for (int i = 0; i < 16; i++) words[i] = 32'h8000_0000 | $urandom_range(32'h0FFF_FFFF, 32'h100);
        words[12] = 32'h0000_0055;
        load_words(16'h0200);
        ref_min(mv, mi);
        push_expect(16'h0400, mi, mv, mv < 32'h0000_0100);
        for (int i = 0; i < 16; i++) words[i] = 32'h4000_0000 + 32'(i * 3);
        words[2] = 32'h0000_0007;
        load_words(16'h0300);
        ref_min(mv, mi);
        push_expect(16'h0410, mi, mv, mv < 32'h0000_0005);
        @(negedge clk);
        hash_addr = 16'h0200; result_addr = 16'h0400; target = 32'h0000_0100; start = 1'b1;
        @(posedge clk);
        #1;
        hash_addr = 16'h0300; result_addr = 16'h0410; target = 32'h0000_0005;
        done_rose = 1'b0;
        started2  = 1'b0;
        edges     = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (e == 20) begin
                started2 = (mem_addr === 16'h0300);
                start = 1'b0;
            end
            if (done) begin
                edges = e;
                break;
            end
            if (e < 40 && done) done_rose = 1'b1;
        end
        checks++; if (started2 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_start got=%h want=0300", mem_addr); end
        checks++; if (edges !== 40) begin failures++; $display("[TB] FAIL b2b_done_edge got=%0d want=40", edges); end
        checks++; if (done_rose !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_gap got=%b want=0", done_rose); end
        checks++; if (best_nonce !== 8'd2) begin failures++; $display("[TB] FAIL b2b_nonce got=%0d want=2", best_nonce); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL b2b_found got=%b want=0", found); end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL b2b_writes_left got=%0d want=0", sb.size()); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        hash_addr   = 16'h0;
        result_addr = 16'h0;
        target      = 32'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        $display("[TB] single minimum");
        test_single_min();
        $display("[TB] tie on minimum");
        test_tie();
        $display("[TB] minimum equal to target");
        test_equal_target();
        $display("[TB] all words ones");
        test_all_ones();
        $display("[TB] address wrap");
        test_addr_wrap();
        $display("[TB] reset during scan and write");
        test_reset_mid_scan();
        $display("[TB] back-to-back start");
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
